// File: rtl/sonar_scan_ctrl_pkg.sv
// Shared definitions for the sonar scan controller: FSM state codes
// (also exported on db_estado) and the ASCII bytes used in result frames.
package sonar_scan_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL    = 4'h0,
        ST_PREPARA    = 4'h1,
        ST_MEDE       = 4'h2,
        ST_ESPERA_MED = 4'h3,
        ST_CARREGA    = 4'h4,
        ST_TX_BYTE    = 4'h5,
        ST_TX_ESPERA  = 4'h6,
        ST_PROX       = 4'h7,
        ST_INTERVALO  = 4'h8,
        ST_FIM        = 4'hF
    } estado_t;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_SEP   = 8'h2C;
    localparam logic [7:0] ASC_FIM   = 8'h23;
    localparam logic [7:0] ASC_INVAL = 8'h2D;

endpackage

// File: rtl/sonar_frame_fmt.sv
// Combinational frame formatter: picks byte byte_idx_i of the frame
// "<canal>,<digits MS first>#" for one channel's BCD result.
// Ports: canal_i (channel), bcd_i (packed BCD), byte_idx_i, tx_dado_o (ASCII).
module sonar_frame_fmt
    import sonar_scan_ctrl_pkg::*;
#(
    parameter int DIGITOS = 3
) (
    input  logic [3:0]           canal_i,
    input  logic [4*DIGITOS-1:0] bcd_i,
    input  logic [3:0]           byte_idx_i,
    output logic [7:0]           tx_dado_o
);

    logic [3:0] digito;

    always_comb begin
        digito = 4'h0;
        // byte 2 carries the most-significant digit
        for (int k = 0; k < DIGITOS; k++) begin
            if (int'(byte_idx_i) == DIGITOS + 1 - k) begin
                digito = bcd_i[4*k +: 4];
            end
        end

        tx_dado_o = ASC_FIM;
        if (byte_idx_i == 4'd0) begin
            tx_dado_o = ASC_ZERO + {4'h0, canal_i};
        end else if (byte_idx_i == 4'd1) begin
            tx_dado_o = ASC_SEP;
        end else if (int'(byte_idx_i) < DIGITOS + 2) begin
            tx_dado_o = (digito > 4'd9) ? ASC_INVAL
                                        : ASC_ZERO + {4'h0, digito};
        end
    end

endmodule

// File: rtl/sonar_scan_ctrl.sv
// Scan controller for N ultrasonic channels: measures one channel at a time,
// stores BCD results (all-ones on timeout) and streams one ASCII frame per
// channel over a start/done TX handshake. Single-shot or periodic scans.
// Ports: clock/reset(async, low), ligar/parar/modo_continuo control,
// medir/med_pronto/med_valor sensor side, tx_dado/tx_partida/tx_pronto TX
// side, sel/db_medida/db_canal/db_estado debug, pronto scan-done flag.
module sonar_scan_ctrl
    import sonar_scan_ctrl_pkg::*;
#(
    parameter  int N_CANAIS         = 3,
    parameter  int DIGITOS          = 3,
    parameter  int TIMEOUT_CICLOS   = 2_500_000,
    parameter  int INTERVALO_CICLOS = 50_000_000,
    localparam int W  = 4 * DIGITOS,
    localparam int SW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ligar,
    input  logic                  parar,
    input  logic                  modo_continuo,
    output logic [N_CANAIS-1:0]   medir,
    input  logic [N_CANAIS-1:0]   med_pronto,
    input  logic [N_CANAIS*W-1:0] med_valor,
    output logic [7:0]            tx_dado,
    output logic                  tx_partida,
    input  logic                  tx_pronto,
    input  logic [SW-1:0]         sel,
    output logic [W-1:0]          db_medida,
    output logic [3:0]            db_canal,
    output logic [3:0]            db_estado,
    output logic                  pronto
);

    localparam int TW = ($clog2(TIMEOUT_CICLOS) > 0) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int IW = ($clog2(INTERVALO_CICLOS) > 0) ? $clog2(INTERVALO_CICLOS) : 1;
    localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [IW-1:0] INT_FIM = IW'(INTERVALO_CICLOS - 1);
    localparam logic [3:0]    BYTE_FIM = 4'(DIGITOS + 2);
    localparam logic [3:0]    CANAL_FIM = 4'(N_CANAIS - 1);

    estado_t             estado_q;
    logic [3:0]          canal_q;
    logic [3:0]          byte_q;
    logic [TW-1:0]       tmo_q;
    logic [IW-1:0]       int_q;
    logic [N_CANAIS-1:0] medir_q;
    logic [7:0]          tx_dado_q;
    logic                tx_partida_q;
    logic                pronto_q;
    logic [W-1:0]        res_q [N_CANAIS];

    logic                pronto_sel;
    logic [W-1:0]        valor_sel;
    logic [W-1:0]        res_sel;
    logic [N_CANAIS-1:0] medir_oh;
    logic [7:0]          dado_d;

    // Per-channel views selected by the current channel index.
    always_comb begin
        pronto_sel = 1'b0;
        valor_sel  = '0;
        res_sel    = '0;
        medir_oh   = '0;
        for (int c = 0; c < N_CANAIS; c++) begin
            if (canal_q == 4'(c)) begin
                pronto_sel  = med_pronto[c];
                valor_sel   = med_valor[c*W +: W];
                res_sel     = res_q[c];
                medir_oh[c] = 1'b1;
            end
        end
    end

    always_comb begin
        db_medida = '0;
        for (int c = 0; c < N_CANAIS; c++) begin
            if (sel == SW'(c)) begin
                db_medida = res_q[c];
            end
        end
    end

    sonar_frame_fmt #(.DIGITOS(DIGITOS)) u_fmt (
        .canal_i    (canal_q),
        .bcd_i      (res_sel),
        .byte_idx_i (byte_q),
        .tx_dado_o  (dado_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= ST_INICIAL;
            canal_q      <= '0;
            byte_q       <= '0;
            tmo_q        <= '0;
            int_q        <= '0;
            medir_q      <= '0;
            tx_dado_q    <= '0;
            tx_partida_q <= 1'b0;
            pronto_q     <= 1'b0;
            for (int c = 0; c < N_CANAIS; c++) begin
                res_q[c] <= '0;
            end
        end else if (parar) begin
            // abort keeps stored results; a late tx_pronto lands in INICIAL
            estado_q     <= ST_INICIAL;
            byte_q       <= '0;
            medir_q      <= '0;
            tx_partida_q <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            medir_q      <= '0;
            tx_partida_q <= 1'b0;
            unique case (estado_q)
                ST_INICIAL, ST_FIM: begin
                    if (ligar) begin
                        canal_q  <= '0;
                        pronto_q <= 1'b0;
                        estado_q <= ST_PREPARA;
                    end
                end
                ST_PREPARA: begin
                    tmo_q    <= '0;
                    medir_q  <= medir_oh;
                    estado_q <= ST_MEDE;
                end
                ST_MEDE: begin
                    estado_q <= ST_ESPERA_MED;
                end
                ST_ESPERA_MED: begin
                    // a real answer wins over a timeout in the same cycle
                    if (pronto_sel || tmo_q == TMO_FIM) begin
                        for (int c = 0; c < N_CANAIS; c++) begin
                            if (canal_q == 4'(c)) begin
                                res_q[c] <= pronto_sel ? valor_sel : '1;
                            end
                        end
                        estado_q <= ST_CARREGA;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_CARREGA: begin
                    tx_dado_q    <= dado_d;
                    tx_partida_q <= 1'b1;
                    estado_q     <= ST_TX_BYTE;
                end
                ST_TX_BYTE: begin
                    estado_q <= ST_TX_ESPERA;
                end
                ST_TX_ESPERA: begin
                    if (tx_pronto) begin
                        if (byte_q == BYTE_FIM) begin
                            byte_q   <= '0;
                            estado_q <= ST_PROX;
                        end else begin
                            byte_q   <= byte_q + 4'd1;
                            estado_q <= ST_CARREGA;
                        end
                    end
                end
                ST_PROX: begin
                    if (canal_q == CANAL_FIM) begin
                        if (modo_continuo) begin
                            int_q    <= '0;
                            estado_q <= ST_INTERVALO;
                        end else begin
                            pronto_q <= 1'b1;
                            estado_q <= ST_FIM;
                        end
                    end else begin
                        canal_q  <= canal_q + 4'd1;
                        estado_q <= ST_PREPARA;
                    end
                end
                ST_INTERVALO: begin
                    if (int_q == INT_FIM) begin
                        canal_q  <= '0;
                        estado_q <= ST_PREPARA;
                    end else begin
                        int_q <= int_q + 1'b1;
                    end
                end
                default: begin
                    estado_q <= ST_INICIAL;
                end
            endcase
        end
    end

    assign medir      = medir_q;
    assign tx_dado    = tx_dado_q;
    assign tx_partida = tx_partida_q;
    assign pronto     = pronto_q;
    assign db_canal   = canal_q;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Testbench for sonar_scan_ctrl: scoreboard of expected TX bytes,
// sensor and UART models, randomized measurement values and latencies.
module tb_sonar_scan_ctrl;

    localparam int N   = 3;
    localparam int D   = 3;
    localparam int W   = 4 * D;
    localparam int TMO = 1000;
    localparam int INT = 500;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           ligar = 1'b0;
    logic           parar = 1'b0;
    logic           modo_continuo = 1'b0;
    logic [N-1:0]   medir;
    logic [N-1:0]   med_pronto = '0;
    logic [N*W-1:0] med_valor = '0;
    logic [7:0]     tx_dado;
    logic           tx_partida;
    logic           tx_pronto = 1'b0;
    logic [1:0]     sel = '0;
    logic [W-1:0]   db_medida;
    logic [3:0]     db_canal;
    logic [3:0]     db_estado;
    logic           pronto;

    sonar_scan_ctrl #(
        .N_CANAIS(N), .DIGITOS(D),
        .TIMEOUT_CICLOS(TMO), .INTERVALO_CICLOS(INT)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .parar(parar),
        .modo_continuo(modo_continuo), .medir(medir),
        .med_pronto(med_pronto), .med_valor(med_valor),
        .tx_dado(tx_dado), .tx_partida(tx_partida), .tx_pronto(tx_pronto),
        .sel(sel), .db_medida(db_medida), .db_canal(db_canal),
        .db_estado(db_estado), .pronto(pronto)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    logic [7:0]   exp_q[$];
    logic [W-1:0] val[N];
    logic [W-1:0] exp_r[N];
    logic [W-1:0] model_res[N];
    bit           ans[N];
    int           dly[N];
    int           cnt[N];

    int spur_cnt = 0;
    bit spur_en = 0;
    bit gap_pending = 0;
    int meas_t = 0;
    int meas_min = 0;
    bit int_chk = 0;
    int t_hash = 0;
    bit tx_busy = 0;
    int tx_dmin = 2;
    int tx_dmax = 10;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Sensor model: answers medir[c] after dly[c] clocks unless silenced.
    initial forever begin
        @(negedge clock);
        med_pronto = '0;
        if (!reset) begin
            for (int c = 0; c < N; c++) cnt[c] = 0;
            spur_cnt = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (medir[c]) begin
                    cnt[c] = ans[c] ? dly[c] : 0;
                    meas_t = cyc;
                    meas_min = ans[c] ? dly[c] : TMO;
                    gap_pending = 1;
                    if (c == 0 && spur_en) spur_cnt = 3;
                    if (c == 0 && int_chk) begin
                        chk_rng("interval", cyc - t_hash, INT, INT + 5);
                        int_chk = 0;
                    end
                end else if (cnt[c] > 0) begin
                    cnt[c]--;
                    if (cnt[c] == 0) med_pronto[c] = 1'b1;
                end
            end
            // stray done pulse from the last channel while another is measured
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) med_pronto[N-1] = 1'b1;
            end
        end
    end

    // UART model + scoreboard monitor.
    logic [7:0] mb;
    int md;
    int mextra;
    bit mstable;
    initial forever begin
        @(negedge clock);
        if (reset && tx_partida) begin
            tx_busy = 1;
            mb = tx_dado;
            if (gap_pending) begin
                chk_rng("meas_latency", cyc - meas_t, meas_min, meas_min + 4);
                gap_pending = 0;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra: got byte %02h required none", mb);
            end else begin
                chk("tx_byte", mb, exp_q.pop_front());
            end
            md = $urandom_range(tx_dmax, tx_dmin);
            mstable = 1;
            mextra = 0;
            repeat (md) begin
                @(negedge clock);
                if (tx_dado !== mb) mstable = 0;
                if (tx_partida) mextra++;
            end
            chk("tx_stable", mstable, 1);
            chk("tx_one_start", mextra, 0);
            if (mb == 8'h23) t_hash = cyc;
            tx_pronto = 1'b1;
            @(negedge clock);
            tx_pronto = 1'b0;
            tx_busy = 0;
        end
    end

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int k = 0; k < D; k++) v[4*k +: 4] = 4'($urandom_range(11, 0));
        return v;
    endfunction

    task automatic prep_scan();
        for (int c = 0; c < N; c++) begin
            med_valor[c*W +: W] = val[c];
            exp_r[c] = ans[c] ? val[c] : {W{1'b1}};
        end
    endtask

    task automatic push_frames();
        logic [3:0] dg;
        for (int c = 0; c < N; c++) begin
            exp_q.push_back(8'(8'h30 + c));
            exp_q.push_back(8'h2C);
            for (int k = D - 1; k >= 0; k--) begin
                dg = exp_r[c][4*k +: 4];
                exp_q.push_back(dg > 4'd9 ? 8'h2D : 8'h30 + {4'h0, dg});
            end
            exp_q.push_back(8'h23);
        end
    endtask

    task automatic pulse_ligar();
        @(negedge clock);
        ligar = 1'b1;
        @(negedge clock);
        ligar = 1'b0;
    endtask

    task automatic wait_state(logic [3:0] st, int budget, string name);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(name, db_estado, st);
    endtask

    task automatic check_store();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("db_medida", db_medida, (s < N) ? model_res[s] : '0);
        end
        sel = '0;
    endtask

    task automatic end_scan();
        int n = 0;
        while (pronto !== 1'b1 && n < 12000) begin
            @(negedge clock);
            n++;
        end
        chk("pronto", pronto, 1);
        chk("estado_fim", db_estado, 4'hF);
        chk("queue_empty", exp_q.size(), 0);
        for (int c = 0; c < N; c++) model_res[c] = exp_r[c];
        check_store();
    endtask

    task automatic rand_setup(bit allow_tmo);
        for (int c = 0; c < N; c++) begin
            val[c] = rand_bcd();
            ans[c] = !allow_tmo || ($urandom_range(4, 0) != 0);
            dly[c] = $urandom_range(80, 10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end required end of run");
        $fatal(1);
    end

    initial begin
        int n;
        for (int c = 0; c < N; c++) begin
            ans[c] = 1;
            dly[c] = 100;
            val[c] = '0;
            model_res[c] = '0;
            cnt[c] = 0;
        end
        repeat (3) @(negedge clock);
        chk("rst_medir", medir, 0);
        chk("rst_partida", tx_partida, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_canal", db_canal, 0);
        chk("rst_dado", tx_dado, 0);
        chk("rst_medida", db_medida, 0);
        reset = 1'b1;
        @(negedge clock);

        // directed single shot; a ligar mid-scan must change nothing
        val[0] = 12'h123;
        val[1] = 12'h045;
        val[2] = 12'h999;
        prep_scan();
        push_frames();
        pulse_ligar();
        repeat (10) @(negedge clock);
        pulse_ligar();
        end_scan();

        // channel 1 silent -> timeout frame and all-ones store
        rand_setup(0);
        ans[1] = 0;
        prep_scan();
        push_frames();
        pulse_ligar();
        end_scan();
        sel = 2'd1;
        #1;
        chk("tmo_store", db_medida, 12'hFFF);
        sel = '0;

        // randomized scans with stray med_pronto and slow TX
        spur_en = 1;
        for (int i = 0; i < 4; i++) begin
            rand_setup(1);
            if (i == 1) begin
                tx_dmin = 37;
                tx_dmax = 37;
            end else begin
                tx_dmin = 2;
                tx_dmax = 40;
            end
            prep_scan();
            push_frames();
            pulse_ligar();
            end_scan();
        end
        spur_en = 0;
        tx_dmin = 2;
        tx_dmax = 10;

        // continuous mode: two scans, then dropped mid-scan -> FIM
        rand_setup(0);
        prep_scan();
        push_frames();
        push_frames();
        modo_continuo = 1'b1;
        pulse_ligar();
        repeat (5) @(negedge clock);
        int_chk = 1;
        n = 0;
        while (int_chk && n < 12000) begin
            @(negedge clock);
            n++;
        end
        chk("interval_seen", int_chk, 0);
        modo_continuo = 1'b0;
        end_scan();

        // abort during TX_ESPERA keeps results, late tx_pronto ignored
        rand_setup(0);
        prep_scan();
        push_frames();
        pulse_ligar();
        wait_state(4'h6, 2000, "reach_tx_espera");
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        chk("abort_estado", db_estado, 0);
        chk("abort_pronto", pronto, 0);
        chk("abort_partida", tx_partida, 0);
        exp_q.delete();
        model_res[0] = exp_r[0];
        n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        chk("late_tx_ignored", db_estado, 0);
        check_store();
        // parar has priority over ligar
        @(negedge clock);
        parar = 1'b1;
        ligar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        ligar = 1'b0;
        chk("parar_prio", db_estado, 0);

        // asynchronous reset while waiting for a measurement
        rand_setup(0);
        prep_scan();
        pulse_ligar();
        wait_state(4'h3, 100, "reach_espera");
        #2;
        reset = 1'b0;
        #1;
        chk("arst_estado", db_estado, 0);
        chk("arst_medir", medir, 0);
        chk("arst_canal", db_canal, 0);
        chk("arst_dado", tx_dado, 0);
        for (int c = 0; c < N; c++) model_res[c] = '0;
        @(negedge clock);
        check_store();
        reset = 1'b1;
        @(negedge clock);

        // normal scan after reset
        rand_setup(1);
        prep_scan();
        push_frames();
        pulse_ligar();
        end_scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
